// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, line levels and sizing helper for the UART blocks
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;
    localparam logic UART_STOP_LVL  = 1'b1;

    function automatic int uart_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter that flags the last cycle of every bit
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_bit_end
);

    localparam int CW = uart_cnt_w(CLKS_PER_BIT);

    logic [CW-1:0] cnt_q;

    assign o_bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));

    // count 0..CLKS_PER_BIT-1, wrapping at bit end and restarting on a state change
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear || o_bit_end) cnt_q <= '0;
        else                               cnt_q <= cnt_q + CW'(1);
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: valid/ready fed serialiser emitting start, LSB-first data and stop bits
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_done
);

    localparam int IW = uart_cnt_w(DATA_W);

    uart_state_t       state_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [IW-1:0]     idx_q;
    logic              tx_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic              bit_end;
    logic              last_bit;
    logic              state_chg;

    assign shift_d   = shift_q >> 1;
    assign last_bit  = (idx_q == IW'(DATA_W - 1));
    assign state_chg = (state_q == IDLE) ? i_valid
                     : bit_end && ((state_q != DATA) || last_bit);

    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (state_chg),
        .o_bit_end (bit_end)
    );

    // frame sequencer; every output is registered alongside the state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= UART_IDLE_LVL;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (i_valid) begin
                    state_q <= START;
                    shift_q <= i_data;
                    tx_q    <= UART_START_LVL;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b1;
                end
                START: if (bit_end) begin
                    state_q <= DATA;
                    idx_q   <= '0;
                    tx_q    <= shift_q[0];
                end
                DATA: if (bit_end) begin
                    shift_q <= shift_d;
                    if (last_bit) begin
                        state_q <= STOP;
                        tx_q    <= UART_STOP_LVL;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                        tx_q  <= shift_d[0];
                    end
                end
                STOP: if (bit_end) begin
                    state_q <= IDLE;
                    tx_q    <= UART_IDLE_LVL;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_tx    = tx_q;
    assign o_ready = ready_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scenario tasks checking serial frames against a bit-level frame model
module tb_uart_tx;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data, data1;
    logic       valid, valid1;
    logic       ready, tx, busy, done;
    logic       ready1, tx1, busy1, done1;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(C), .DATA_W(8)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid),
        .o_ready(ready), .o_tx(tx), .o_busy(busy), .o_done(done)
    );

    uart_tx #(.CLKS_PER_BIT(1), .DATA_W(8)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_data(data1), .i_valid(valid1),
        .o_ready(ready1), .o_tx(tx1), .o_busy(busy1), .o_done(done1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // expects to be in cycle T+1 after the handshake; leaves off in the done cycle T+41
    task automatic check_frame(input logic [7:0] b, input string name, input int pulse_k);
        logic [9:0] fr;
        logic [7:0] got;
        logic [3:0] exp, obs;
        fr  = {1'b1, b, 1'b0};
        got = '0;
        for (int k = 0; k < 10 * C; k++) begin
            exp = {fr[k / C], 3'b010};
            obs = {tx, ready, busy, done};
            if (k / C >= 1 && k / C <= 8 && k % C == C / 2) got[k / C - 1] = tx;
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL %s cycle T+%0d tx/ready/busy/done got %b expected %b", name, k + 1, obs, exp);
            end
            if (k == pulse_k) begin valid = 1'b1; data = 8'hFF; end
            if (pulse_k >= 0 && k == pulse_k + 1) valid = 1'b0;
            step();
        end
        checks++;
        if (got !== b) begin
            failures++;
            $display("FAIL %s decoded byte got %h expected %h", name, got, b);
        end
        checks++;
        if ({tx, ready, busy, done} !== 4'b1101) begin
            failures++;
            $display("FAIL %s done cycle tx/ready/busy/done got %b expected 1101", name, {tx, ready, busy, done});
        end
    endtask

    task automatic check_idle(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            checks++;
            if ({tx, ready, busy, done} !== 4'b1100) begin
                failures++;
                $display("FAIL %s idle tx/ready/busy/done got %b expected 1100", name, {tx, ready, busy, done});
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b1; data = 8'($urandom); valid1 = 1'b1; data1 = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({tx, ready, busy, done, tx1, ready1, busy1, done1} !== 8'b1100_1100) begin
                failures++;
                $display("FAIL reset got %b expected 11001100", {tx, ready, busy, done, tx1, ready1, busy1, done1});
            end
        end
        rst = 1'b0; valid = 1'b0; valid1 = 1'b0;
        step();
        check_idle("after_reset", 2);
    endtask

    task automatic test_a5();
        valid = 1'b1; data = 8'hA5;
        step();
        valid = 1'b0; data = 8'($urandom);
        check_frame(8'hA5, "a5", -1);
        step();
        check_idle("a5_post", 2);
    endtask

    task automatic test_back_to_back();
        valid = 1'b1; data = 8'h00;
        step();
        data = 8'hFF;
        check_frame(8'h00, "b2b_first", -1);
        step();
        valid = 1'b0;
        check_frame(8'hFF, "b2b_second", -1);
        step();
        check_idle("b2b_post", 2);
    endtask

    task automatic test_ignore_busy();
        valid = 1'b1; data = 8'h3C;
        step();
        valid = 1'b0;
        check_frame(8'h3C, "ignore", 9);
        step();
        check_idle("ignore_post", 6);
    endtask

    task automatic test_reset_mid();
        valid = 1'b1; data = 8'h5A;
        step();
        valid = 1'b0;
        for (int i = 0; i < 17; i++) step();
        checks++;
        if (tx !== 1'b1) begin
            failures++;
            $display("FAIL mid_bit3 tx got %b expected 1", tx);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("mid_reset", 6);
        valid = 1'b1; data = 8'h3C;
        step();
        valid = 1'b0;
        check_frame(8'h3C, "after_mid_reset", -1);
        step();
    endtask

    task automatic test_random();
        logic [7:0] b;
        for (int n = 0; n < 5; n++) begin
            b = 8'($urandom);
            check_idle("rand_gap", $urandom_range(0, 3));
            valid = 1'b1; data = b;
            step();
            valid = 1'b0; data = 8'($urandom);
            check_frame(b, "rand", -1);
            step();
        end
    endtask

    task automatic test_cpb1();
        logic [9:0] fr;
        fr = {1'b1, 8'h81, 1'b0};
        valid1 = 1'b1; data1 = 8'h81;
        step();
        valid1 = 1'b0; data1 = 8'($urandom);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if ({tx1, done1} !== {fr[k], 1'b0}) begin
                failures++;
                $display("FAIL cpb1 cycle %0d tx/done got %b expected %b", k + 1, {tx1, done1}, {fr[k], 1'b0});
            end
            step();
        end
        checks++;
        if ({tx1, ready1, busy1, done1} !== 4'b1101) begin
            failures++;
            $display("FAIL cpb1 done cycle got %b expected 1101", {tx1, ready1, busy1, done1});
        end
        step();
    endtask

    initial begin
        test_reset();
        test_a5();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        test_random();
        test_cpb1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
